// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM write queue: FSM states and command entry sizing.
package vram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RELEASE,
        ST_HALT
    } state_t;

    localparam int DEF_WORD_WIDTH    = 16;
    localparam int DEF_ADDRESS_WIDTH = 16;

    // Command entry layout is {write, address, wdata}.
    localparam int CMD_WIDTH = DEF_ADDRESS_WIDTH + DEF_WORD_WIDTH + 1;

    function automatic int entry_width(input int aw, input int ww);
        return aw + ww + 1;
    endfunction

endpackage

// File: rtl/vram_write_queue_if.sv
// CPU-side access bus and encoder-side request/busy bus of the VRAM write queue.
interface vram_write_queue_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int WORD_WIDTH    = 16
);
    // CPU side
    logic                     cpu_valid;
    logic                     cpu_write;
    logic [ADDRESS_WIDTH-1:0] cpu_address;
    logic [WORD_WIDTH-1:0]    cpu_wdata;
    logic                     cpu_ready;
    logic [WORD_WIDTH-1:0]    cpu_rdata;
    logic                     cpu_rdata_valid;

    // Encoder side
    logic                     request;
    logic                     busy;
    logic                     initialized;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write_enable;
    logic [WORD_WIDTH-1:0]    data_out;
    logic [WORD_WIDTH-1:0]    data_in;

    modport cpu_mst (
        output cpu_valid, cpu_write, cpu_address, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_rdata_valid
    );
    modport cpu_slv (
        input  cpu_valid, cpu_write, cpu_address, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_rdata_valid
    );
    modport enc_mst (
        output request, address, write_enable, data_out,
        input  busy, initialized, data_in
    );
    modport enc_slv (
        input  request, address, write_enable, data_out,
        output busy, initialized, data_in
    );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset since the count qualifies them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/vram_write_queue.sv
// Queues CPU memory accesses and replays them in order to the SPI SRAM encoder.
module vram_write_queue
    import vram_pkg::*;
#(
    parameter int WORD_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int START_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    vram_write_queue_if.cpu_slv         cpu,
    vram_write_queue_if.enc_mst         enc,
    output logic                        drained,
    output logic [$clog2(FIFO_DEPTH):0] pending,
    output logic                        overflow,
    output logic                        timeout_error
);
    localparam int EW = entry_width(ADDRESS_WIDTH, WORD_WIDTH);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    state_t                   state_q, state_d;
    logic                     req_q, req_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic [WORD_WIDTH-1:0]    wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     rvld_q, rvld_d;
    logic                     ovf_q, ovf_d;
    logic                     tmo_q, tmo_d;
    logic [TW-1:0]            tcnt_q, tcnt_d;

    logic                     push, pop, full, empty;
    logic [EW-1:0]            head;

    assign push = cpu.cpu_valid && cpu.cpu_ready;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({cpu.cpu_write, cpu.cpu_address, cpu.cpu_wdata}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    assign cpu.cpu_ready       = !full;
    assign cpu.cpu_rdata       = rdata_q;
    assign cpu.cpu_rdata_valid = rvld_q;
    assign enc.request         = req_q;
    assign enc.address         = addr_q;
    assign enc.write_enable    = we_q;
    assign enc.data_out        = wdata_q;
    assign drained             = empty && (state_q == ST_IDLE) && !req_q;
    assign overflow            = ovf_q;
    assign timeout_error       = tmo_q;

    // Launch/handshake FSM: next state, pop strobe and output register updates.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rvld_d  = 1'b0;
        tmo_d   = tmo_q;
        tcnt_d  = tcnt_q;
        pop     = 1'b0;
        // A dropped push is remembered until reset.
        ovf_d   = ovf_q | (cpu.cpu_valid && !cpu.cpu_ready);
        case (state_q)
            ST_IDLE: begin
                if (enc.initialized && !empty) begin
                    pop     = 1'b1;
                    we_d    = head[EW-1];
                    addr_d  = head[EW-2 -: ADDRESS_WIDTH];
                    wdata_d = head[WORD_WIDTH-1:0];
                    req_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (enc.busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tcnt_q == TW'(START_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_HALT;
                end else begin
                    tcnt_d  = tcnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!enc.busy) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = enc.data_in;
                        rvld_d  = 1'b1;
                    end
                    state_d = ST_RELEASE;
                end
            end
            // One guaranteed low cycle on request before the next launch.
            ST_RELEASE: state_d = ST_IDLE;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            rvld_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
        end
    end
endmodule

// File: doc/vram_write_queue.md
Name: vram_write_queue

Overview:
- Upstream feeder for spi_sram_encoder.
- Accepts Hack-CPU style memory accesses (address, write flag, write data) into a small in-order command FIFO.
- Replays each entry to the encoder using its request/busy handshake, and returns read data to the CPU side.
- Decouples a CPU that issues one access per cycle from the multi-cycle SPI transactions; also provides the drain-complete indication used before handing the SRAM bus to the video reader.

Parameters:
- WORD_WIDTH, 16, data word width.
- ADDRESS_WIDTH, 16, SRAM word address width.
- FIFO_DEPTH, 4, command entries; power of two, at least 2.
- START_TIMEOUT, 64, max cycles from request assertion to busy seen high before error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_valid  in  1  command strobe; accepted when cpu_ready=1.
- cpu_write  in  1  1=write, 0=read.
- cpu_address  in  ADDRESS_WIDTH  word address.
- cpu_wdata  in  WORD_WIDTH  write data.
- cpu_ready  out  1  FIFO not full.
- cpu_rdata  out  WORD_WIDTH  read data, held until the next read completes.
- cpu_rdata_valid  out  1  one-cycle pulse per completed read.
- drained  out  1  FIFO empty, FSM in IDLE, request low.
- pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: cpu_valid seen while cpu_ready=0.
- timeout_error  out  1  sticky: START_TIMEOUT expired.
- request  out  1  to encoder request.
- busy  in  1  from encoder busy.
- initialized  in  1  from encoder initialized.
- address  out  ADDRESS_WIDTH  to encoder address.
- write_enable  out  1  to encoder write_enable.
- data_out  out  WORD_WIDTH  to encoder data_out (write data).
- data_in  in  WORD_WIDTH  from encoder data_in (read data).

Behaviour:
- Reset values:
  - request=0, cpu_ready=1, cpu_rdata=0, cpu_rdata_valid=0.
  - drained=1, pending=0, overflow=0, timeout_error=0.
  - address/write_enable/data_out=0; FIFO pointers 0; FSM=IDLE.
- Reset asserted mid-transaction aborts immediately and discards queued entries; the encoder is reset separately by the top.
- FIFO:
  - Push when cpu_valid && cpu_ready.
  - Pop when IDLE launches an entry.
  - Push and pop in the same cycle leaves pending unchanged.
  - cpu_ready = (pending != FIFO_DEPTH), derived combinationally from the registered count.
  - A push while full is dropped and sets overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if initialized && pending!=0, pop the head into the address/write_enable/data_out registers, set request=1 and the timeout counter to 0, then go to WAIT_BUSY. Otherwise hold.
  - WAIT_BUSY: request held 1. If busy=1, go to WAIT_DONE. Otherwise increment the counter; at START_TIMEOUT set timeout_error, drop request, go to HALT.
  - WAIT_DONE: request held 1. On busy=0:
    - request<=0;
    - if !write_enable, capture data_in into cpu_rdata and pulse cpu_rdata_valid in the next cycle;
    - go to RELEASE.
  - RELEASE: request=0 for exactly one cycle, guaranteeing the encoder sees a low gap; go to IDLE.
  - HALT: terminal until reset. request=0; FIFO still accepts pushes until full.
- Latency:
  - Earliest launch is the cycle after the push: request rises 1 cycle after the accepting edge.
  - Minimum back-to-back spacing is encoder transaction + 2 cycles.
- Address/data registers are stable for the whole time request=1.
- Ordering is strictly FIFO, so a read after a write to the same address returns the new data.
- initialized=0 only stalls launching. It does not affect an in-flight transaction.
- drained is combinational from state and count.

Decomposition:
- Shared package vram_pkg:
  - FSM state localparams (IDLE, WAIT_BUSY, WAIT_DONE, RELEASE, HALT);
  - command entry width constant = ADDRESS_WIDTH+WORD_WIDTH+1.
- One sub-module, sync_fifo: parameterised width/depth; push/pop/full/empty/count; async active-high reset.
- The FSM lives in vram_write_queue.

Test Plan:
- Basic write: initialized=1, push write addr 0x0005 data 0xFF00.
  - request rises 1 cycle later with address=0x0005, write_enable=1, data_out=0xFF00.
  - Encoder model busy 20 cycles → request falls the cycle after busy falls; drained=1 two cycles later.
- Read-after-write: push write 0x0010/0x00FF then read 0x0010; model returns 0x00FF → exactly one cpu_rdata_valid pulse with cpu_rdata=0x00FF.
- Full/overflow: initialized=0, push 5 commands with FIFO_DEPTH=4.
  - cpu_ready=0 after the 4th, overflow=1 after the 5th, pending=4.
  - Raise initialized → 4 transactions in order, 5th absent.
- Simultaneous push/pop at pending=4: push on the pop cycle accepted only when cpu_ready=1; pending stays consistent, no entry lost or duplicated (scoreboard).
- Timeout: model never asserts busy → timeout_error=1 exactly START_TIMEOUT=64 cycles after request rises, request=0, FSM halts.
- Mid-transaction reset: assert reset during WAIT_DONE → request=0 asynchronously, pending=0, drained=1, flags cleared.
